// File: rtl/ram_march_bist.sv
// -----------------------------------------------------------------------------
// ram_march_bist
//   March C- built-in self-test initiator for a single-port synchronous RAM.
//   It writes the RAM through ram_data/ram_addr/ram_write and checks ram_q.
//   The first mismatch stops the run and reports the failing address and the
//   value read back.
//
//   Parameters
//     ADDR_W    RAM address width (depth = 2**ADDR_W)
//     DATA_W    RAM data width, must be even
//
//   Ports
//     clk         rising-edge clock, shared with the RAM
//     rst_n       asynchronous active-low reset
//     start       run request, sampled only in IDLE
//     busy        high while a run is in progress
//     done        one-cycle pulse at the end of a run (pass or fail)
//     fail        sticky mismatch flag, cleared by the next accepted start
//     fail_addr   address of the first mismatch
//     fail_data   value read at the first mismatch
//     ram_data    to RAM data
//     ram_addr    to RAM addr
//     ram_write   to RAM write
//     ram_q       from RAM q
//
//   Configuration macro
//     RAM_BIST_CHECKERBOARD_EN  when defined, a second full M0..M5 pass runs
//                               with backgrounds 0101.. / 1010..
//
//   RAM read contract: a read cycle (ram_write=0) registers ram_addr in the
//   RAM; ram_q is valid in the following cycle and is not disturbed by a
//   write cycle, since a write does not load the RAM address register.
// -----------------------------------------------------------------------------
module ram_march_bist #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              fail,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data,
   output logic [DATA_W-1:0] ram_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_write,
   input  logic [DATA_W-1:0] ram_q
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_M0_W   = 3'd1,
      S_RW_RD  = 3'd2,
      S_RW_WR  = 3'd3,
      S_M5_RD  = 3'd4,
      S_M5_CHK = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
   localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [DATA_W-1:0] DATA_ZERO = '0;
`ifdef RAM_BIST_CHECKERBOARD_EN
   localparam logic [DATA_W-1:0] CB_PAT    = {(DATA_W/2){2'b01}};
`endif

   localparam logic [2:0] EL_M0 = 3'd0;
   localparam logic [2:0] EL_M1 = 3'd1;
   localparam logic [2:0] EL_M2 = 3'd2;
   localparam logic [2:0] EL_M3 = 3'd3;
   localparam logic [2:0] EL_M4 = 3'd4;
   localparam logic [2:0] EL_M5 = 3'd5;

   // Elements M3/M4 walk the address space downwards.
   function automatic logic elem_down(input logic [2:0] el);
      return (el == EL_M3) || (el == EL_M4);
   endfunction

   // M2/M4 read B1 and write B0; M1/M3 read B0 and write B1.
   function automatic logic elem_reads_b1(input logic [2:0] el);
      return (el == EL_M2) || (el == EL_M4);
   endfunction

   state_t              state_r, state_n;
   logic [2:0]          elem_r, elem_n;
   logic [ADDR_W-1:0]   addr_r, addr_n;
   logic [DATA_W-1:0]   data_r, data_n;
   logic                wr_r, wr_n;
   logic                busy_r, busy_n;
   logic                done_r, done_n;
   logic                fail_r, fail_n;
   logic [ADDR_W-1:0]   fail_addr_r, fail_addr_n;
   logic [DATA_W-1:0]   fail_data_r, fail_data_n;
`ifdef RAM_BIST_CHECKERBOARD_EN
   logic                pass_r, pass_n;
`endif

   logic [DATA_W-1:0]   bg0_s, bg1_s;
   logic [DATA_W-1:0]   exp_rd_s;
   logic [ADDR_W-1:0]   cmp_addr_s;
   logic                mismatch_s;

`ifdef RAM_BIST_CHECKERBOARD_EN
   assign bg0_s = pass_r ? CB_PAT : DATA_ZERO;
`else
   assign bg0_s = DATA_ZERO;
`endif
   assign bg1_s = ~bg0_s;

   // Compare ram_q against the value expected from the read issued last cycle.
   always_comb begin
      mismatch_s = 1'b0;
      cmp_addr_s = addr_r;
      exp_rd_s   = bg0_s;
      case (state_r)
         S_RW_WR: begin
            exp_rd_s   = elem_reads_b1(elem_r) ? bg1_s : bg0_s;
            mismatch_s = (ram_q != exp_rd_s);
         end
         S_M5_RD: begin
            // At address 0 there is no earlier M5 read to check yet.
            cmp_addr_s = addr_r - ADDR_ONE;
            mismatch_s = (addr_r != ADDR_ZERO) && (ram_q != bg0_s);
         end
         S_M5_CHK: begin
            mismatch_s = (ram_q != bg0_s);
         end
         default: begin
            mismatch_s = 1'b0;
         end
      endcase
   end

   // Next-state and next-output logic of the march sequencer.
   always_comb begin
      state_n     = state_r;
      elem_n      = elem_r;
      addr_n      = addr_r;
      data_n      = data_r;
      wr_n        = 1'b0;
      busy_n      = busy_r;
      done_n      = 1'b0;
      fail_n      = fail_r;
      fail_addr_n = fail_addr_r;
      fail_data_n = fail_data_r;
`ifdef RAM_BIST_CHECKERBOARD_EN
      pass_n      = pass_r;
`endif
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_n     = S_M0_W;
               elem_n      = EL_M0;
               addr_n      = ADDR_ZERO;
               data_n      = DATA_ZERO;
               wr_n        = 1'b1;
               busy_n      = 1'b1;
               fail_n      = 1'b0;
               fail_addr_n = ADDR_ZERO;
               fail_data_n = DATA_ZERO;
`ifdef RAM_BIST_CHECKERBOARD_EN
               pass_n      = 1'b0;
`endif
            end else begin
               state_n = S_IDLE;
            end
         end
         S_M0_W: begin
            if (addr_r == ADDR_MAX) begin
               state_n = S_RW_RD;
               elem_n  = EL_M1;
               addr_n  = ADDR_ZERO;
            end else begin
               addr_n  = addr_r + ADDR_ONE;
               data_n  = bg0_s;
               wr_n    = 1'b1;
            end
         end
         S_RW_RD: begin
            state_n = S_RW_WR;
            data_n  = elem_reads_b1(elem_r) ? bg0_s : bg1_s;
            wr_n    = 1'b1;
         end
         S_RW_WR: begin
            if (mismatch_s) begin
               state_n     = S_DONE;
               busy_n      = 1'b0;
               done_n      = 1'b1;
               fail_n      = 1'b1;
               fail_addr_n = cmp_addr_s;
               fail_data_n = ram_q;
            end else if (elem_down(elem_r) ? (addr_r == ADDR_ZERO)
                                           : (addr_r == ADDR_MAX)) begin
               // Element boundary: reload the address for the next direction.
               if (elem_r == EL_M4) begin
                  state_n = S_M5_RD;
                  elem_n  = EL_M5;
                  addr_n  = ADDR_ZERO;
               end else begin
                  state_n = S_RW_RD;
                  elem_n  = elem_r + 3'd1;
                  addr_n  = elem_down(elem_r + 3'd1) ? ADDR_MAX : ADDR_ZERO;
               end
            end else begin
               state_n = S_RW_RD;
               addr_n  = elem_down(elem_r) ? (addr_r - ADDR_ONE)
                                           : (addr_r + ADDR_ONE);
            end
         end
         S_M5_RD: begin
            if (mismatch_s) begin
               state_n     = S_DONE;
               busy_n      = 1'b0;
               done_n      = 1'b1;
               fail_n      = 1'b1;
               fail_addr_n = cmp_addr_s;
               fail_data_n = ram_q;
            end else if (addr_r == ADDR_MAX) begin
               state_n = S_M5_CHK;
            end else begin
               addr_n  = addr_r + ADDR_ONE;
            end
         end
         S_M5_CHK: begin
            if (mismatch_s) begin
               state_n     = S_DONE;
               busy_n      = 1'b0;
               done_n      = 1'b1;
               fail_n      = 1'b1;
               fail_addr_n = cmp_addr_s;
               fail_data_n = ram_q;
`ifdef RAM_BIST_CHECKERBOARD_EN
            end else if (!pass_r) begin
               // Solid pass clean: rerun everything on checkerboard backgrounds.
               pass_n  = 1'b1;
               state_n = S_M0_W;
               elem_n  = EL_M0;
               addr_n  = ADDR_ZERO;
               data_n  = CB_PAT;
               wr_n    = 1'b1;
`endif
            end else begin
               state_n = S_DONE;
               busy_n  = 1'b0;
               done_n  = 1'b1;
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
            busy_n  = 1'b0;
         end
         default: begin
            state_n = S_IDLE;
            busy_n  = 1'b0;
         end
      endcase
   end

   // State and registered-output update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         elem_r      <= EL_M0;
         addr_r      <= ADDR_ZERO;
         data_r      <= DATA_ZERO;
         wr_r        <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         fail_r      <= 1'b0;
         fail_addr_r <= ADDR_ZERO;
         fail_data_r <= DATA_ZERO;
`ifdef RAM_BIST_CHECKERBOARD_EN
         pass_r      <= 1'b0;
`endif
      end else begin
         state_r     <= state_n;
         elem_r      <= elem_n;
         addr_r      <= addr_n;
         data_r      <= data_n;
         wr_r        <= wr_n;
         busy_r      <= busy_n;
         done_r      <= done_n;
         fail_r      <= fail_n;
         fail_addr_r <= fail_addr_n;
         fail_data_r <= fail_data_n;
`ifdef RAM_BIST_CHECKERBOARD_EN
         pass_r      <= pass_n;
`endif
      end
   end

   // The registered write request is withdrawn in the cycle whose compare
   // fails, so a faulty cell is never overwritten with the next background.
   assign ram_write = wr_r & ~mismatch_s;
   assign ram_addr  = addr_r;
   assign ram_data  = data_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign fail      = fail_r;
   assign fail_addr = fail_addr_r;
   assign fail_data = fail_data_r;

endmodule

// File: tb/tb_ram_march_bist.sv
module tb_ram_march_bist;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       busy, done, fail;
   logic [5:0] fail_addr;
   logic [7:0] fail_data;
   logic [7:0] ram_data;
   logic [5:0] ram_addr;
   logic       ram_write;
   logic [7:0] ram_q;

   int checks = 0;
   int errors = 0;

   ram_march_bist #(.ADDR_W(6), .DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .busy(busy), .done(done), .fail(fail),
      .fail_addr(fail_addr), .fail_data(fail_data),
      .ram_data(ram_data), .ram_addr(ram_addr), .ram_write(ram_write),
      .ram_q(ram_q)
   );

   always #5 clk = ~clk;

   // RAM model with selectable fault: 1 = addr37 bit3 SA1, 2 = addr63 bit0 SA0,
   // 3 = AND bridge bits 0/1 at addr 5.
   logic [7:0] mem [0:63];
   logic [5:0] addr_reg = 6'd0;
   int         fault_sel = 0;

   always @(posedge clk) begin
      if (ram_write) mem[ram_addr] <= ram_data;
      else           addr_reg      <= ram_addr;
   end

   always_comb begin
      logic [7:0] rd;
      logic       b;
      rd = mem[addr_reg];
      b  = rd[0] & rd[1];
      case (fault_sel)
         1: if (addr_reg == 6'd37) rd[3] = 1'b1;
         2: if (addr_reg == 6'd63) rd[0] = 1'b0;
         3: if (addr_reg == 6'd5) begin rd[0] = b; rd[1] = b; end
         default: ;
      endcase
      ram_q = rd;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Start a run and sample every cycle (at negedge) until done or timeout.
   task automatic run_to_done(input bit hold, output int cyc, output int wr_cnt,
                              output logic pw, output logic [5:0] pa);
      @(negedge clk); start = 1'b1;
      @(posedge clk);                 // E0
      @(negedge clk); if (!hold) start = 1'b0;
      cyc = 1; wr_cnt = 0; pw = 1'b0; pa = 6'd0;
      check("busy_cycle1", {31'd0, busy}, 32'd1);
      check("fail_cleared", {31'd0, fail}, 32'd0);
      check("fail_addr_cleared", {26'd0, fail_addr}, 32'd0);
      while (!done && cyc < 3000) begin
         if (ram_write) wr_cnt++;
         pw = ram_write; pa = ram_addr;
         @(negedge clk);
         cyc++;
      end
      check("done_seen", {31'd0, done}, 32'd1);
      check("busy_at_done", {31'd0, busy}, 32'd0);
   endtask

   typedef struct {
      string      name;
      int         fault;
      int         done_cyc;
      logic       fail;
      logic [5:0] faddr;
      logic [7:0] fdata;
      int         writes;
      bit         chk_nowr;
   } vec_t;

`ifdef RAM_BIST_CHECKERBOARD_EN
   localparam int FULL_DONE = 1283;
   localparam int FULL_WR   = 640;
`else
   localparam int FULL_DONE = 642;
   localparam int FULL_WR   = 320;
`endif

   initial begin
      vec_t       vecs[4];
      int         cyc, wr_cnt;
      logic       pw;
      logic [5:0] pa;

      vecs[0] = '{"clean",    0, FULL_DONE, 1'b0, 6'd0,  8'h00, FULL_WR, 1'b0};
      vecs[1] = '{"sa1_a37",  1, 141,       1'b1, 6'd37, 8'h08, 101,     1'b1};
      vecs[2] = '{"sa0_a63",  2, 321,       1'b1, 6'd63, 8'hFE, 191,     1'b1};
`ifdef RAM_BIST_CHECKERBOARD_EN
      vecs[3] = '{"bridge_a5", 3, 718,      1'b1, 6'd5,  8'h54, 389,     1'b1};
`else
      vecs[3] = '{"bridge_a5", 3, 642,      1'b0, 6'd0,  8'h00, 320,     1'b0};
`endif

      // Reset state
      #12;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_fail", {31'd0, fail}, 32'd0);
      check("rst_write", {31'd0, ram_write}, 32'd0);
      check("rst_addr", {26'd0, ram_addr}, 32'd0);
      check("rst_data", {24'd0, ram_data}, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < 4; i++) begin
         fault_sel = vecs[i].fault;
         run_to_done(1'b0, cyc, wr_cnt, pw, pa);
         check({vecs[i].name, "_done_cyc"}, cyc, vecs[i].done_cyc);
         check({vecs[i].name, "_fail"}, {31'd0, fail}, {31'd0, vecs[i].fail});
         check({vecs[i].name, "_fail_addr"}, {26'd0, fail_addr}, {26'd0, vecs[i].faddr});
         check({vecs[i].name, "_fail_data"}, {24'd0, fail_data}, {24'd0, vecs[i].fdata});
         check({vecs[i].name, "_writes"}, wr_cnt, vecs[i].writes);
         if (vecs[i].chk_nowr) begin
            check({vecs[i].name, "_nowrite_failcyc"}, {31'd0, pw}, 32'd0);
            check({vecs[i].name, "_failcyc_addr"}, {26'd0, pa}, {26'd0, vecs[i].faddr});
         end
         @(negedge clk);
         check({vecs[i].name, "_done_pulse"}, {31'd0, done}, 32'd0);
         check({vecs[i].name, "_idle"}, {31'd0, busy}, 32'd0);
      end

      // Asynchronous reset at cycle 300 of a clean run, then a clean rerun.
      fault_sel = 0;
      @(negedge clk); start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      for (int c = 1; c < 300; c++) @(negedge clk);
      check("midrun_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_write", {31'd0, ram_write}, 32'd0);
      check("arst_addr", {26'd0, ram_addr}, 32'd0);
      check("arst_data", {24'd0, ram_data}, 32'd0);
      check("arst_done", {31'd0, done}, 32'd0);
      check("arst_fail_addr", {26'd0, fail_addr}, 32'd0);
      check("arst_fail_data", {24'd0, fail_data}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      run_to_done(1'b0, cyc, wr_cnt, pw, pa);
      check("post_rst_done_cyc", cyc, FULL_DONE);
      check("post_rst_fail", {31'd0, fail}, 32'd0);

      // start held through a whole run, dropped in the DONE cycle: one run only.
      @(negedge clk);
      run_to_done(1'b1, cyc, wr_cnt, pw, pa);
      check("hold1_done_cyc", cyc, FULL_DONE);
      start = 1'b0;
      @(negedge clk);
      check("hold1_idle_a", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("hold1_idle_b", {31'd0, busy}, 32'd0);

      // start still high in the IDLE cycle after done: a second run starts.
      run_to_done(1'b1, cyc, wr_cnt, pw, pa);
      check("hold2_done_cyc", cyc, FULL_DONE);
      @(negedge clk);
      check("hold2_idle", {31'd0, busy}, 32'd0);
      check("hold2_no_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      check("hold2_restart", {31'd0, busy}, 32'd1);
      start = 1'b0;
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
